paillier_demo_encry_top: RTL and testbench
==========================================

// Module: paillier_demo_encry_top
// PURPOSE
//  Paillier encryption with g = n+1: result = (1 + m*n) * r^n mod n^2.
//  Counterpart of the decryption top: produces the ciphertext c that the decryption top consumes.
//  Sequences one shared bit-serial modular multiplier through an FSM (m*n, square-and-multiply r^n, final product).
//  The caller supplies n and exp_n = n^2, both fitting in RSA_WIDTH bits.
// PARAMETERS
//  RSA_WIDTH    4096  operand/result width; exp_n < 2^RSA_WIDTH
//  DATA_WIDTH   128   bus word width, carried for codebase consistency; no effect on datapath
//  DATA_NUMBER  32    RSA_WIDTH/DATA_WIDTH, carried for consistency; no effect on datapath
// PORTS
//  clk     in   1          single clock, rising edge
//  rst     in   1          asynchronous, active-high reset
//  go      in   1          start request, sampled only in IDLE
//  m       in   RSA_WIDTH  plaintext, m < n
//  r       in   RSA_WIDTH  random nonce, 0 < r < n
//  n       in   RSA_WIDTH  public modulus (exponent for r)
//  exp_n   in   RSA_WIDTH  n^2, the reduction modulus
//  result  out  RSA_WIDTH  ciphertext c; held until next accepted go
//  busy    out  1          high from the cycle after go is accepted until done
//  done    out  1          one-cycle pulse, result valid in the same cycle
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: result=0, done=0, busy=0, FSM=IDLE, all internal registers cleared. rst mid-operation aborts immediately; no done.
//  Accept: in IDLE with go=1, latch m,r,n,exp_n and go busy; inputs are don't-care afterwards. go while busy ignored.
//  FSM: IDLE -> MN (T=m*n mod exp_n) -> INC (T=T+1; T==exp_n wraps to 0) -> EXP_SQ/EXP_MUL -> FINAL (result=T*R mod exp_n) -> DONE -> IDLE.
//  Exponent: K = index of highest set bit of n; R=r; for bits K-1..0: EXP_SQ R=R*R, and if bit set EXP_MUL R=R*r.
//   n==0: R=1 and the exponent loop is skipped. n==1: R=r, no loop iterations.
//  Modmul count M = 2 + K + (popcount(n)-1); for n==0: M = 2.
//  Each modmul takes exactly RSA_WIDTH+2 cycles (load, RSA_WIDTH bit steps, finish).
//  Latency: done rises exactly 2 + M*(RSA_WIDTH+2) cycles after the go-sampling edge; fixed per n, independent of m and r.
//  DONE: result registered, done=1 one cycle, busy drops with done; go in the following IDLE cycle is accepted (back-to-back OK).
//  Modmul rule (interleaved, MSB-first over b): acc = 2*acc + (b[i] ? a : 0), then subtract exp_n up to twice so acc < exp_n.
//   acc is RSA_WIDTH+2 bits wide; no overflow while a,b < exp_n. Operands >= exp_n are out of contract; no range check.
//  busy, done and result change only on clk edges; no combinational path from inputs to outputs.
// STRUCTURE
//  paillier_pkg: encryption FSM state enum, modmul opcode select (MN/SQ/MUL/FINAL), default RSA_WIDTH.
//  Sub-module paillier_modmul_serial (start/a/b/mod -> done/p): the only arithmetic unit.
//  The top holds the FSM, operand muxing, T/R registers and the exponent bit pointer.
// TESTING  (RSA_WIDTH=64 for sim speed unless stated)
//  1. n=3, exp_n=9, m=1, r=2 -> result=5, done 1 cycle, M=4, latency 2+4*66 cycles.
//  2. n=5, exp_n=25, m=2, r=3 -> T=11, R=18, result=23.
//  3. n=209, exp_n=43681, m=0, r=1 -> result=1; rerun with RSA_WIDTH=4096, same result.
//  4. Modmul unit alone: a=b=43680, mod=43681 -> p=1 after exactly 66 cycles.
//  5. Start case 2, assert rst during EXP_SQ -> result=0, busy=0, no done; release rst, run case 1 -> result=5.
//  6. Hold go high throughout: toggling inputs while busy does not alter result; second run begins the cycle after done.

Source files
------------

// File: rtl/paillier_pkg.sv
// Shared types for the Paillier encryption datapath: FSM states, modmul operand select,
// default operand width.
package paillier_pkg;

   localparam int unsigned RsaWidthDefault = 4096;

   typedef enum logic [2:0] {
      StIdle,
      StMn,
      StInc,
      StExpSq,
      StExpMul,
      StFinal,
      StDone
   } enc_state_e;

   typedef enum logic [1:0] {
      OpMn,
      OpSq,
      OpMul,
      OpFinal
   } mm_op_e;

   typedef enum logic [1:0] {
      MmIdle,
      MmStep,
      MmFinish
   } mm_state_e;

endpackage

// File: rtl/paillier_demo_encry_if.sv
// Request/response bundle of the encryption top; signal suffixes are from the slave's view.
interface paillier_demo_encry_if
   import paillier_pkg::*;
#(
   parameter int unsigned RSA_WIDTH = RsaWidthDefault
);
   logic                 go_i;
   logic [RSA_WIDTH-1:0] m_i;
   logic [RSA_WIDTH-1:0] r_i;
   logic [RSA_WIDTH-1:0] n_i;
   logic [RSA_WIDTH-1:0] exp_n_i;
   logic [RSA_WIDTH-1:0] result_o;
   logic                 busy_o;
   logic                 done_o;

   modport master (
      output go_i, m_i, r_i, n_i, exp_n_i,
      input  result_o, busy_o, done_o
   );

   modport slave (
      input  go_i, m_i, r_i, n_i, exp_n_i,
      output result_o, busy_o, done_o
   );
endinterface

// File: rtl/paillier_modmul_serial.sv
// Bit-serial interleaved modular multiplier: p = a*b mod mod, MSB-first over b.
// One load cycle, RSA_WIDTH step cycles, one finish cycle with done high.
module paillier_modmul_serial
   import paillier_pkg::*;
#(
   parameter int unsigned RSA_WIDTH = RsaWidthDefault
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [RSA_WIDTH-1:0] a_i,
   input  logic [RSA_WIDTH-1:0] b_i,
   input  logic [RSA_WIDTH-1:0] mod_i,
   output logic                 done_o,
   output logic [RSA_WIDTH-1:0] p_o
);

   localparam int unsigned CntW = $clog2(RSA_WIDTH);

   mm_state_e            state_q, state_d;
   logic [RSA_WIDTH+1:0] acc_q, acc_d;
   logic [RSA_WIDTH-1:0] a_q, a_d, b_q, b_d, mod_q, mod_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [RSA_WIDTH+1:0] s0, s1, s2, mod_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MmIdle;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mod_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mod_q   <= mod_d;
         cnt_q   <= cnt_d;
      end
   end

   // acc < mod on entry, so 2*acc + a < 3*mod: two conditional subtractions suffice
   always_comb begin
      mod_ext = {2'b00, mod_q};
      s0 = (acc_q << 1) + (b_q[RSA_WIDTH-1] ? {2'b00, a_q} : '0);
      s1 = (s0 >= mod_ext) ? s0 - mod_ext : s0;
      s2 = (s1 >= mod_ext) ? s1 - mod_ext : s1;
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      mod_d   = mod_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         MmIdle: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               mod_d   = mod_i;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MmStep;
            end
         end
         MmStep: begin
            acc_d = s2;
            b_d   = b_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(RSA_WIDTH - 1)) state_d = MmFinish;
         end
         MmFinish: state_d = MmIdle;
         default:  state_d = MmIdle;
      endcase
   end

   assign done_o = (state_q == MmFinish);
   assign p_o    = acc_q[RSA_WIDTH-1:0];

endmodule

// File: rtl/paillier_demo_encry_top.sv
// Paillier encryption with g = n+1: result = (1 + m*n) * r^n mod n^2, sequenced over a
// single shared serial modular multiplier.
module paillier_demo_encry_top
   import paillier_pkg::*;
#(
   parameter int unsigned RSA_WIDTH   = RsaWidthDefault,
   parameter int unsigned DATA_WIDTH  = 128,
   parameter int unsigned DATA_NUMBER = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   paillier_demo_encry_if.slave  bus
);

   localparam int unsigned IdxW = $clog2(RSA_WIDTH);

   if (DATA_WIDTH == 0 || DATA_NUMBER == 0) begin : g_bad_cfg
      $error("DATA_WIDTH and DATA_NUMBER must be non-zero");
   end

   enc_state_e           state_q, state_d;
   logic [RSA_WIDTH-1:0] m_q, m_d, r_q, r_d, n_q, n_d, e_q, e_d;
   logic [RSA_WIDTH-1:0] t_q, t_d, rr_q, rr_d, result_q, result_d;
   logic [IdxW-1:0]      idx_q, idx_d, msb_idx;
   logic                 busy_q, busy_d, done_q, done_d, run_q, run_d;

   logic                 mm_start, mm_done;
   logic [RSA_WIDTH-1:0] mm_a, mm_b, mm_p, t_inc;
   mm_op_e               mm_op;

   paillier_modmul_serial #(
      .RSA_WIDTH (RSA_WIDTH)
   ) u_modmul (
      .clk     (clk),
      .rst     (rst),
      .start_i (mm_start),
      .a_i     (mm_a),
      .b_i     (mm_b),
      .mod_i   (e_q),
      .done_o  (mm_done),
      .p_o     (mm_p)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         m_q      <= '0;
         r_q      <= '0;
         n_q      <= '0;
         e_q      <= '0;
         t_q      <= '0;
         rr_q     <= '0;
         result_q <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         r_q      <= r_d;
         n_q      <= n_d;
         e_q      <= e_d;
         t_q      <= t_d;
         rr_q     <= rr_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         run_q    <= run_d;
      end
   end

   always_comb begin
      msb_idx = '0;
      for (int unsigned i = 0; i < RSA_WIDTH; i++) begin
         if (n_q[i]) msb_idx = IdxW'(i);
      end
   end

   always_comb begin
      mm_op = OpMn;
      unique case (state_q)
         StExpSq:  mm_op = OpSq;
         StExpMul: mm_op = OpMul;
         StFinal:  mm_op = OpFinal;
         default:  mm_op = OpMn;
      endcase
      unique case (mm_op)
         OpMn:    begin mm_a = m_q;  mm_b = n_q;  end
         OpSq:    begin mm_a = rr_q; mm_b = rr_q; end
         OpMul:   begin mm_a = rr_q; mm_b = r_q;  end
         OpFinal: begin mm_a = t_q;  mm_b = rr_q; end
         default: begin mm_a = m_q;  mm_b = n_q;  end
      endcase
   end

   // A multiply is launched in the first cycle of each operand state; the run flag keeps
   // every state exactly one modmul long.
   assign mm_start = (state_q inside {StMn, StExpSq, StExpMul, StFinal}) && !run_q;
   assign t_inc    = t_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      r_d      = r_q;
      n_d      = n_q;
      e_d      = e_q;
      t_d      = t_q;
      rr_d     = rr_q;
      result_d = result_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      run_d    = mm_start ? 1'b1 : (mm_done ? 1'b0 : run_q);
      unique case (state_q)
         StIdle: begin
            if (bus.go_i) begin
               m_d     = bus.m_i;
               r_d     = bus.r_i;
               n_d     = bus.n_i;
               e_d     = bus.exp_n_i;
               busy_d  = 1'b1;
               state_d = StMn;
            end
         end
         StMn: begin
            if (mm_done) begin
               t_d     = mm_p;
               state_d = StInc;
            end
         end
         StInc: begin
            t_d = (t_inc == e_q) ? '0 : t_inc;
            if (n_q == '0) begin
               rr_d    = RSA_WIDTH'(1);
               state_d = StFinal;
            end else begin
               rr_d = r_q;
               if (msb_idx == '0) begin
                  state_d = StFinal;
               end else begin
                  idx_d   = msb_idx - 1'b1;
                  state_d = StExpSq;
               end
            end
         end
         StExpSq: begin
            if (mm_done) begin
               rr_d = mm_p;
               if (n_q[idx_q]) begin
                  state_d = StExpMul;
               end else if (idx_q == '0) begin
                  state_d = StFinal;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
         StExpMul: begin
            if (mm_done) begin
               rr_d = mm_p;
               if (idx_q == '0) begin
                  state_d = StFinal;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = StExpSq;
               end
            end
         end
         StFinal: begin
            if (mm_done) begin
               t_d     = mm_p;
               state_d = StDone;
            end
         end
         StDone: begin
            result_d = t_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.result_o = result_q;
   assign bus.busy_o   = busy_q;
   assign bus.done_o   = done_q;

endmodule

// File: tb/tb_paillier_demo_encry_top.sv
// Directed bench for the Paillier encryption top and its serial modular multiplier.
module tb_paillier_demo_encry_top;

   localparam int unsigned W     = 64;
   localparam int          Bound = 20000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   paillier_demo_encry_if #(.RSA_WIDTH(W)) bus_if ();

   paillier_demo_encry_top #(
      .RSA_WIDTH (W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   logic         mm_start, mm_done;
   logic [W-1:0] mm_a, mm_b, mm_mod, mm_p;

   paillier_modmul_serial #(
      .RSA_WIDTH (W)
   ) u_mm (
      .clk     (clk),
      .rst     (rst),
      .start_i (mm_start),
      .a_i     (mm_a),
      .b_i     (mm_b),
      .mod_i   (mm_mod),
      .done_o  (mm_done),
      .p_o     (mm_p)
   );

   int total  = 0;
   int passes = 0;
   int cyc;
   int seen;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic apply(input logic [W-1:0] m, input logic [W-1:0] r,
                        input logic [W-1:0] n, input logic [W-1:0] e);
      bus_if.m_i     = m;
      bus_if.r_i     = r;
      bus_if.n_i     = n;
      bus_if.exp_n_i = e;
   endtask

   // Count edges after the accepting edge until done is seen (bounded).
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (bus_if.done_o !== 1'b1 && cycles < Bound) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic run_case(input string tag, input logic [W-1:0] m, input logic [W-1:0] r,
                           input logic [W-1:0] n, input logic [W-1:0] e,
                           input logic [W-1:0] exp_res, input int exp_lat);
      int c;
      apply(m, r, n, e);
      bus_if.go_i = 1'b1;
      @(posedge clk);
      #1;
      bus_if.go_i = 1'b0;
      chk({tag, "_busy_on"}, W'(bus_if.busy_o), 1);
      wait_done(c);
      chk({tag, "_latency"}, W'(c), W'(exp_lat));
      chk({tag, "_result"}, bus_if.result_o, exp_res);
      chk({tag, "_busy_off"}, W'(bus_if.busy_o), 0);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, W'(bus_if.done_o), 0);
      chk({tag, "_result_hold"}, bus_if.result_o, exp_res);
   endtask

   initial begin
      rst         = 1'b1;
      bus_if.go_i = 1'b0;
      apply('0, '0, '0, '0);
      mm_start = 1'b0;
      mm_a     = '0;
      mm_b     = '0;
      mm_mod   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_result", bus_if.result_o, 0);
      chk("reset_busy", W'(bus_if.busy_o), 0);
      chk("reset_done", W'(bus_if.done_o), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // (1+m*n)*r^n mod n^2; latency 2 + M*(W+2)
      run_case("c1", 1, 2, 3, 9, 5, 266);
      run_case("wrap", 2, 3, 2, 5, 0, 200);
      run_case("n0", 3, 5, 0, 7, 1, 134);
      run_case("n1", 3, 7, 1, 10, 8, 134);
      run_case("c2", 2, 3, 5, 25, 23, 332);
      run_case("c3", 0, 1, 209, 43681, 1, 794);
      run_case("c2b", 2, 3, 5, 25, 23, 332);

      // Abort during the exponent loop
      apply(2, 3, 5, 25);
      bus_if.go_i = 1'b1;
      @(posedge clk);
      #1;
      bus_if.go_i = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_result", bus_if.result_o, 0);
      chk("abort_busy", W'(bus_if.busy_o), 0);
      chk("abort_done", W'(bus_if.done_o), 0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      seen = 0;
      repeat (400) begin
         @(posedge clk);
         #1;
         if (bus_if.done_o === 1'b1) seen++;
      end
      chk("abort_no_done", W'(seen), 0);
      run_case("after_abort", 1, 2, 3, 9, 5, 266);

      // go held high; inputs change while busy, second run starts right after done
      apply(1, 2, 3, 9);
      bus_if.go_i = 1'b1;
      @(posedge clk);
      #1;
      apply(2, 3, 5, 25);
      chk("held_busy_on", W'(bus_if.busy_o), 1);
      wait_done(cyc);
      chk("held_latency1", W'(cyc), 266);
      chk("held_result1", bus_if.result_o, 5);
      @(posedge clk);
      #1;
      chk("held_rerun_busy", W'(bus_if.busy_o), 1);
      chk("held_rerun_done", W'(bus_if.done_o), 0);
      bus_if.go_i = 1'b0;
      wait_done(cyc);
      chk("held_latency2", W'(cyc), 332);
      chk("held_result2", bus_if.result_o, 23);
      @(posedge clk);
      #1;

      // Multiplier alone: cycle with start counts as 1, done cycle is W+2
      mm_a     = 43680;
      mm_b     = 43680;
      mm_mod   = 43681;
      mm_start = 1'b1;
      cyc      = 1;
      @(posedge clk);
      #1;
      mm_start = 1'b0;
      cyc++;
      while (mm_done !== 1'b1 && cyc < Bound) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("mm_cycles", W'(cyc), W'(W + 2));
      chk("mm_p_neg1sq", mm_p, 1);
      @(posedge clk);
      #1;
      chk("mm_done_pulse", W'(mm_done), 0);

      mm_a     = 7;
      mm_b     = 5;
      mm_mod   = 9;
      mm_start = 1'b1;
      @(posedge clk);
      #1;
      mm_start = 1'b0;
      cyc      = 0;
      while (mm_done !== 1'b1 && cyc < Bound) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("mm_p_35mod9", mm_p, 8);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
